// File: rtl/dog_subtract.sv
// dog_subtract: streams three Gaussian-blurred images of one octave out of their BRAMs and
// writes the two Difference-of-Gaussian images (G1-G0, G2-G1) into two signed DoG BRAMs.
//
// Ports:
//   clk, rst_in              clock, synchronous active-high reset
//   start                    one-cycle pass request, ignored while busy
//   read_address             shared address to the three Gaussian BRAMs
//   gauss0/1/2_data          unsigned pixels returned BRAM_LATENCY cycles after the address
//   dog_address, dog_we      shared write address / enable for both DoG BRAMs
//   first/second_dog_data    signed G1-G0 and G2-G1
//   busy                     high from the cycle after start is accepted until done
//   done                     one-cycle pulse after the last write
module dog_subtract #(
  parameter int unsigned BIT_DEPTH    = 8,
  parameter int unsigned DIMENSION    = 4,
  parameter int unsigned BRAM_LATENCY = 2,
  localparam int unsigned N           = DIMENSION * DIMENSION,
  localparam int unsigned AW          = $clog2(N)
) (
  input  logic                        clk,
  input  logic                        rst_in,
  input  logic                        start,
  output logic [AW-1:0]               read_address,
  input  logic [BIT_DEPTH-1:0]        gauss0_data,
  input  logic [BIT_DEPTH-1:0]        gauss1_data,
  input  logic [BIT_DEPTH-1:0]        gauss2_data,
  output logic [AW-1:0]               dog_address,
  output logic signed [BIT_DEPTH:0]   first_dog_data,
  output logic signed [BIT_DEPTH:0]   second_dog_data,
  output logic                        dog_we,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned Last = BRAM_LATENCY - 1;

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e                      state_q, state_d;
  logic [AW-1:0]               rd_addr_q, rd_addr_d;
  logic                        done_q, done_d;

  // (valid, address) travelling alongside the BRAM read latency
  logic [BRAM_LATENCY-1:0]     vld_q;
  logic [AW-1:0]               pipe_addr_q [BRAM_LATENCY];

  logic                        we_q;
  logic [AW-1:0]               dog_addr_q;
  logic signed [BIT_DEPTH:0]   first_q, second_q;

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StRead;
          rd_addr_d = '0;
        end
      end
      StRead: begin
        if (rd_addr_q == AW'(N - 1)) begin
          state_d = StDrain;
        end else begin
          rd_addr_d = rd_addr_q + AW'(1);
        end
      end
      StDrain: begin
        // The write of the final address is on the bus this cycle
        if (we_q && (dog_addr_q == AW'(N - 1))) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q    <= StIdle;
      rd_addr_q  <= '0;
      done_q     <= 1'b0;
      vld_q      <= '0;
      for (int i = 0; i < int'(BRAM_LATENCY); i++) begin
        pipe_addr_q[i] <= '0;
      end
      we_q       <= 1'b0;
      dog_addr_q <= '0;
      first_q    <= '0;
      second_q   <= '0;
    end else begin
      state_q        <= state_d;
      rd_addr_q      <= rd_addr_d;
      done_q         <= done_d;
      vld_q[0]       <= (state_q == StRead);
      pipe_addr_q[0] <= rd_addr_q;
      for (int i = 1; i < int'(BRAM_LATENCY); i++) begin
        vld_q[i]       <= vld_q[i-1];
        pipe_addr_q[i] <= pipe_addr_q[i-1];
      end
      we_q <= vld_q[Last];
      // Data/address hold their last values between writes
      if (vld_q[Last]) begin
        dog_addr_q <= pipe_addr_q[Last];
        first_q    <= $signed({1'b0, gauss1_data}) - $signed({1'b0, gauss0_data});
        second_q   <= $signed({1'b0, gauss2_data}) - $signed({1'b0, gauss1_data});
      end
    end
  end

  assign read_address    = rd_addr_q;
  assign dog_address     = dog_addr_q;
  assign first_dog_data  = first_q;
  assign second_dog_data = second_q;
  assign dog_we          = we_q;
  assign busy            = (state_q != StIdle);
  assign done            = done_q;

endmodule
